regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter CNT_W, default 2: width of each per-register pending-write counter; maximum count is 2^CNT_W-1.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ws_to_rf_bus  input  `WS_TO_RF_BUS_WD (40)  write-back bus: [39] gr_we, [38] ws_valid, [37] rf_we, [36:32] waddr, [31:0] wdata.
REQ-005 raddr1/raddr2  input  5 each  read addresses from the decode stage.
REQ-006 rdata1/rdata2  output  32 each  read data.
REQ-007 busy1/busy2  output  1 each  a write to raddr1/raddr2 is still in flight; decode stalls on it.
REQ-008 issue_valid  input  1  decode issues an instruction that writes a GPR this cycle.
REQ-009 issue_dest  input  5  destination register of the issued instruction.
REQ-010 flush  input  1  pipeline flush; clears all pending state.
REQ-011 sb_full  output  1  counter of issue_dest is at maximum; decode must not issue.

Function
REQ-012 Register array: 32 x 32 bits; entry 0 reads 0 always and is never written.
REQ-013 Write: at posedge clk, if rf_we and waddr!=0, array[waddr] <= wdata.
REQ-014 Read: combinational; raddr==0 returns 0; otherwise array[raddr], subject to REQ-024.
REQ-015 Retire event: ws_valid && gr_we && waddr!=0.
REQ-016 Issue event: issue_valid && issue_dest!=0 && !flush.
REQ-017 Counters: one per register 1..31; issue event increments cnt[issue_dest]; retire event decrements cnt[waddr].
REQ-018 Issue and retire on the same register in the same cycle leave that counter unchanged.
REQ-019 Increment at maximum saturates; counter unchanged. Issuing while sb_full=1 is a protocol violation.
REQ-020 Decrement at 0 saturates at 0; no underflow.
REQ-021 flush=1: all counters become 0 at the next edge; it overrides same-cycle issue and retire. The array write of REQ-013 still occurs.
REQ-022 busyN = (raddrN!=0) && cnt[raddrN]!=0, subject to REQ-024; combinational.
REQ-023 sb_full = (issue_dest!=0) && cnt[issue_dest]==max; combinational.

Reset
REQ-024 While reset is asserted, all array entries and all counters are 0 asynchronously.
REQ-025 During reset, rdata1/rdata2 = 0, busy1/busy2 = 0, and sb_full = 0, regardless of bus contents.
REQ-026 Reset asserted mid-operation discards in-flight writes and counts; no write occurs on the edge where reset is high.

Configuration
REQ-027 Macro RF_WB_BYPASS_EN defined: when rf_we && waddr==raddrN && raddrN!=0, rdataN = wdata in the same cycle. busyN excludes a counter whose value is 1 while a retire to raddrN is in progress this cycle.
REQ-028 Macro RF_WB_BYPASS_EN undefined: rdataN always comes from the array, and busyN uses the raw counter. Decode stalls one extra cycle on a WB-stage dependency.

Structure
REQ-029 `WS_TO_RF_BUS_WD and the bus field-position defines live in the shared header mycpu.h; the write-back stage uses the same defines.
REQ-030 Sub-module rf_sb_cnt: one saturating up/down counter with inc, dec, clr and async reset; instantiated 31 times.

Verification
REQ-031 Reset, then read r5 and r0 -> rdata = 0, busy = 0, sb_full = 0.
REQ-032 Issue r3; two cycles later, WB bus write r3 = 0x1234_5678 with raddr1=3. Bypass build: rdata1 = 0x12345678 and busy1 = 0 that cycle. Non-bypass build: busy1 = 1 that cycle, then 0 with rdata1 = 0x12345678 next cycle.
REQ-033 Issue r7 three times -> cnt = 3 and sb_full = 1 with issue_dest=7. A fourth issue leaves cnt = 3. Three retires -> busy = 0.
REQ-034 Issue r9 and retire r9 in the same cycle, with cnt = 1 beforehand -> cnt stays 1.
REQ-035 WB write to r0 with 0xFFFF_FFFF -> r0 reads 0, and no counter changes.
REQ-036 Pending counts on r2 and r4, then flush with a simultaneous issue to r6 -> all busy = 0 next cycle, and r6 is not pending. A retire to r2 after the flush leaves its counter at 0.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared types for the register file / scoreboard slice; the bus width and field
// positions mirror mycpu.h so the write-back stage and this block agree on layout.
`ifndef WS_TO_RF_BUS_WD
`define WS_TO_RF_BUS_WD 40
`endif

package regfile_sb_pkg;

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    // Field order matches the bus: [39] gr_we, [38] ws_valid, [37] rf_we, [36:32] waddr, [31:0] wdata
    typedef struct packed {
        logic          gr_we;
        logic          ws_valid;
        logic          rf_we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
    } ws_bus_t;

    function automatic logic is_gpr(input logic [AW-1:0] a);
        return a != '0;
    endfunction

endpackage

// File: rtl/regfile_sb_cnt.sv
// Per-register saturating pending-write counter: clr wins, inc and dec together hold,
// and both ends saturate.
module rf_sb_cnt #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// 32x32 register file with a per-register pending-write scoreboard.
// Optional macro RF_WB_BYPASS_EN forwards the write-back bus to the read ports.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [`WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
    input  logic [4:0]                  raddr1,
    input  logic [4:0]                  raddr2,
    output logic [31:0]                 rdata1,
    output logic [31:0]                 rdata2,
    output logic                        busy1,
    output logic                        busy2,
    input  logic                        issue_valid,
    input  logic [4:0]                  issue_dest,
    input  logic                        flush,
    output logic                        sb_full
);

    ws_bus_t          bus;
    logic [DW-1:0]    rf [NREG];
    logic [CNT_W-1:0] cnt [NREG];
    logic             retire;
    logic             issue;

    assign bus    = ws_bus_t'(ws_to_rf_bus);
    assign retire = bus.ws_valid && bus.gr_we && is_gpr(bus.waddr);
    assign issue  = issue_valid && is_gpr(issue_dest) && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (bus.rf_we && is_gpr(bus.waddr)) begin
            rf[bus.waddr] <= bus.wdata;
        end
    end

    assign cnt[0] = '0;

    for (genvar g = 1; g < NREG; g++) begin : g_cnt
        localparam logic [AW-1:0] IDX = AW'(g);
        rf_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (issue && issue_dest == IDX),
            .dec   (retire && bus.waddr == IDX),
            .clr   (flush),
            .cnt   (cnt[g])
        );
    end

    logic [AW-1:0] ra [2];
    logic [DW-1:0] rd [2];
    logic          bz [2];

    assign ra[0] = raddr1;
    assign ra[1] = raddr2;

    // Outputs are forced to zero under reset so bus contents cannot leak through the bypass.
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            rd[p] = '0;
            bz[p] = 1'b0;
            if (!reset && is_gpr(ra[p])) begin
                rd[p] = rf[ra[p]];
                bz[p] = cnt[ra[p]] != '0;
`ifdef RF_WB_BYPASS_EN
                if (bus.rf_we && bus.waddr == ra[p]) begin
                    rd[p] = bus.wdata;
                end
                if (retire && bus.waddr == ra[p] && cnt[ra[p]] == CNT_W'(1)) begin
                    bz[p] = 1'b0;
                end
`endif
            end
        end
    end

    assign rdata1  = rd[0];
    assign rdata2  = rd[1];
    assign busy1   = bz[0];
    assign busy2   = bz[1];
    assign sb_full = !reset && is_gpr(issue_dest) && cnt[issue_dest] == '1;

endmodule
